// File: rtl/pad_in_filter.sv
// Receive-side pad conditioner: two-flop synchroniser, attribute inversion and a
// consecutive-cycle debounce with registered level, edge and glitch-reject pulses.
module pad_in_filter #(
   parameter int AttrDw   = 6,
   parameter int CntWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                pad_in_i,
   input  logic [AttrDw-1:0]   attr_i,
   input  logic                en_i,
   input  logic [CntWidth-1:0] thresh_i,
   output logic                filt_o,
   output logic                rise_o,
   output logic                fall_o,
   output logic                glitch_o
);

   typedef enum logic {STABLE = 1'b0, SETTLE = 1'b1} state_e;

   state_e              state_reg, state_next;
   logic [CntWidth-1:0] cnt_reg, cnt_next;
   logic                s1_reg, s2_reg;
   logic                filt_reg, filt_next;
   logic                rise_reg, rise_next;
   logic                fall_reg, fall_next;
   logic                glitch_reg, glitch_next;

   logic                in_c;
   logic                mismatch;
   logic [CntWidth:0]   cnt_inc;
   logic                hit;
   logic                unused_attr;

   // Only the invert bit matters here; the rest belong to the pad driver side.
   assign unused_attr = ^attr_i;

   assign in_c     = s2_reg ^ attr_i[0];
   assign mismatch = (in_c != filt_reg);
   // One extra bit so the increment and compare can never wrap.
   assign cnt_inc  = {1'b0, cnt_reg} + {{CntWidth{1'b0}}, 1'b1};
   assign hit      = (cnt_inc >= {1'b0, thresh_i});

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_reg     <= 1'b0;
         s2_reg     <= 1'b0;
         state_reg  <= STABLE;
         cnt_reg    <= '0;
         filt_reg   <= 1'b0;
         rise_reg   <= 1'b0;
         fall_reg   <= 1'b0;
         glitch_reg <= 1'b0;
      end else begin
         s1_reg     <= pad_in_i;
         s2_reg     <= s1_reg;
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         filt_reg   <= filt_next;
         rise_reg   <= rise_next;
         fall_reg   <= fall_next;
         glitch_reg <= glitch_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (!en_i) begin
         state_next = STABLE;
         cnt_next   = '0;
      end else if (mismatch) begin
         if (hit) begin
            state_next = STABLE;
            cnt_next   = '0;
         end else begin
            state_next = SETTLE;
            cnt_next   = cnt_inc[CntWidth-1:0];
         end
      end else begin
         state_next = STABLE;
         cnt_next   = '0;
      end
   end

   always_comb begin
      filt_next   = filt_reg;
      rise_next   = 1'b0;
      fall_next   = 1'b0;
      glitch_next = 1'b0;
      if (en_i) begin
         if (mismatch && hit) begin
            filt_next = in_c;
            rise_next = in_c;
            fall_next = ~in_c;
         end else if (!mismatch && (state_reg == SETTLE)) begin
            glitch_next = 1'b1;
         end
      end
   end

   assign filt_o   = filt_reg;
   assign rise_o   = rise_reg;
   assign fall_o   = fall_reg;
   assign glitch_o = glitch_reg;

endmodule
